// File: rtl/sq_wave_meter.sv
// sq_wave_meter: measures the high and low durations of an asynchronous
// square wave in units of sysclk_period clock cycles. One on/off pair is
// published on every rising edge once the meter has locked to the wave.
module sq_wave_meter #(
    parameter int sysclk_period = 10,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wave_in,
    output logic [CNT_W-1:0] on_count,
    output logic [CNT_W-1:0] off_count,
    output logic             meas_valid,
    output logic             overflow,
    output logic             active
);

    localparam int               PRE_W    = $clog2(sysclk_period);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(sysclk_period - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0] UNIT_MAX = '1;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Input conditioning
    logic s1_q, s2_q, s3_q;
    logic rise, fall, edge_det;

    // Prescaler and unit counter
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] unit_q, unit_d;
    logic             sat_q, sat_d;

    // FSM, holds and published results
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_on_q, hold_on_d;
    logic             hold_sat_q, hold_sat_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, independent of order.
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= wave_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Rising and falling edges share the same pipeline depth, so the
    // measured durations carry no synchronizer bias.
    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign edge_det = rise | fall;

    // Prescaler: an edge restarts the phase with the edge cycle already
    // counted; otherwise every sysclk_period cycles advance the unit count.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // block leaves it unassigned, which would infer a latch.
        pre_d  = pre_q;
        unit_d = unit_q;
        sat_d  = sat_q;
        if (edge_det) begin
            pre_d  = PRE_ONE;
            unit_d = '0;
            sat_d  = 1'b0;
        end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (unit_q == UNIT_MAX) begin
                sat_d = 1'b1;
            end else begin
                unit_d = unit_q + CNT_W'(1);
            end
        end else begin
            pre_d = pre_q + PRE_ONE;
        end
    end

    // Phase tracking: SYNC skips the startup partial phase, HIGH captures
    // the high time on the fall, LOW publishes the full pair on the rise.
    always_comb begin
        state_d    = state_q;
        hold_on_d  = hold_on_q;
        hold_sat_d = hold_sat_q;
        on_d       = on_q;
        off_d      = off_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    hold_on_d  = unit_q;
                    hold_sat_d = sat_q;
                    state_d    = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    on_d    = hold_on_q;
                    off_d   = unit_q;
                    ovf_d   = hold_sat_q | sat_q;
                    valid_d = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    // Counter, FSM and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            unit_q     <= '0;
            sat_q      <= 1'b0;
            state_q    <= ST_SYNC;
            hold_on_q  <= '0;
            hold_sat_q <= 1'b0;
            on_q       <= '0;
            off_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            unit_q     <= unit_d;
            sat_q      <= sat_d;
            state_q    <= state_d;
            hold_on_q  <= hold_on_d;
            hold_sat_q <= hold_sat_d;
            on_q       <= on_d;
            off_q      <= off_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign on_count   = on_q;
    assign off_count  = off_q;
    assign overflow   = ovf_q;
    assign meas_valid = valid_q;
    assign active     = (state_q != ST_SYNC);

endmodule

// File: tb/tb_sq_wave_meter.sv
// Self-checking bench for sq_wave_meter. Phase lengths are chosen by the
// bench (fixed tables and $urandom); the expected pair for each period is
// floor(cycles / sysclk_period) clamped to the counter range.
module tb_sq_wave_meter;

    localparam int P    = 10;
    localparam int W    = 8;
    localparam int UMAX = (1 << W) - 1;

    typedef struct packed {
        int unsigned cyc;
        logic        ovf;
        logic [W-1:0] off;
        logic [W-1:0] on;
    } pub_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tb_wave = 1'b0;
    logic wave_in;
    logic [W-1:0] on_count, off_count;
    logic meas_valid, overflow, active;

    // Generator model used by the last scenario
    logic gen_en = 1'b0;
    logic gen_wave = 1'b0;
    int   gen_cnt = 0;
    logic sb_lvl = 1'b1;
    int   sb_run = 0;
    int   sb_h[$];
    int   sb_l[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          act_cyc = -1;
    int          first_rise = -1;
    pub_t        got_q[$];
    pub_t        exp_q[$];
    int          ph[$];
    int          pl[$];

    assign wave_in = gen_en ? gen_wave : tb_wave;

    sq_wave_meter #(.sysclk_period(P), .CNT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wave_in    (wave_in),
        .on_count   (on_count),
        .off_count  (off_count),
        .meas_valid (meas_valid),
        .overflow   (overflow),
        .active     (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every publish and the first cycle active is seen high.
    always @(negedge clk) begin
        if (!reset) begin
            if (meas_valid) begin
                pub_t p;
                p.cyc = cyc;
                p.ovf = overflow;
                p.off = off_count;
                p.on  = on_count;
                got_q.push_back(p);
            end
            if (active && act_cyc < 0) act_cyc <= int'(cyc);
        end
    end

    // Square-wave generator: on_period = 4 units, off_period = 7 units.
    always @(negedge clk) begin
        if (gen_en) begin
            if (gen_cnt == (gen_wave ? 4 * P : 7 * P) - 1) begin
                gen_wave <= ~gen_wave;
                gen_cnt  <= 0;
            end else begin
                gen_cnt <= gen_cnt + 1;
            end
        end
    end

    // Scoreboard: run lengths of the generator output in clk cycles.
    always @(posedge clk) begin
        if (gen_en) begin
            if (wave_in == sb_lvl) begin
                sb_run <= sb_run + 1;
            end else begin
                if (sb_lvl) sb_h.push_back(sb_run);
                else        sb_l.push_back(sb_run);
                sb_lvl <= wave_in;
                sb_run <= 1;
            end
        end
    end

    function automatic pub_t model(input int h, input int l, input int c);
        pub_t p;
        int hu = h / P;
        int lu = l / P;
        p.on  = W'((hu > UMAX) ? UMAX : hu);
        p.off = W'((lu > UMAX) ? UMAX : lu);
        p.ovf = (hu > UMAX) || (lu > UMAX);
        p.cyc = c;
        return p;
    endfunction

    task automatic phase(input logic lvl, input int n);
        tb_wave = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tb_wave = 1'b0;
        gen_en  = 1'b0;
        repeat (3) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        act_cyc = -1;
        reset   = 1'b0;
    endtask

    // Drives low 20, then each (ph[i], pl[i]) period, then a closing rise.
    task automatic play();
        int rc;
        exp_q.delete();
        phase(1'b0, 20);
        for (int i = 0; i < ph.size(); i++) begin
            rc = int'(cyc);
            if (i == 0) first_rise = rc;
            else exp_q.push_back(model(ph[i-1], pl[i-1], rc + 3));
            phase(1'b1, ph[i]);
            phase(1'b0, pl[i]);
        end
        rc = int'(cyc);
        exp_q.push_back(model(ph[ph.size()-1], pl[pl.size()-1], rc + 3));
        phase(1'b1, 10);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({on_count, off_count, meas_valid, overflow, active} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got on=%0d off=%0d mv=%b ovf=%b act=%b, expected all 0",
                     on_count, off_count, meas_valid, overflow, active);
        end
        do_reset();
        repeat (5) @(negedge clk);
        n_tests++;
        if ({on_count, off_count, meas_valid, overflow, active} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got on=%0d off=%0d mv=%b ovf=%b act=%b, expected all 0",
                     on_count, off_count, meas_valid, overflow, active);
        end
    endtask

    task automatic test_basic();
        do_reset();
        ph = '{50};
        pl = '{30};
        play();
        n_tests++;
        if (act_cyc !== first_rise + 3) begin
            n_fail++;
            $display("FAIL basic_active: active rose at cycle %0d, expected %0d", act_cyc, first_rise + 3);
        end
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_pub[%0d]: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_periodic();
        do_reset();
        ph = '{59, 59, 59, 59};
        pl = '{60, 60, 60, 60};
        play();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL periodic_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL periodic_pub[%0d]: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ph = '{3000, 50};
        pl = '{20, 30};
        play();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL sat_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sat_pub[%0d]: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    // Exact multiples, one below, 1-cycle phases back to back, and the
    // saturation threshold from both sides.
    task automatic test_boundary();
        do_reset();
        ph = '{10, 9, 30, 1, 1, 1, 2559, 2560, 20};
        pl = '{9, 10, 29, 1, 1, 1, 19, 2559, 2560};
        play();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bound_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bound_pub[%0d]: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rc1;
        int rc2;
        pub_t e;
        do_reset();
        ph = '{50};
        pl = '{30};
        play();
        n_tests++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rmid_first: got %0d publishes, expected one with on=5 off=3", got_q.size());
        end
        phase(1'b1, 15);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({on_count, off_count, meas_valid, overflow, active} !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear: got on=%0d off=%0d mv=%b ovf=%b act=%b, expected all 0",
                     on_count, off_count, meas_valid, overflow, active);
        end
        repeat (2) @(negedge clk);
        got_q.delete();
        reset = 1'b0;
        phase(1'b1, 20);
        phase(1'b0, 30);
        n_tests++;
        if (got_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rmid_quiet: got %0d publishes before rise-fall-rise, expected 0", got_q.size());
        end
        rc1 = int'(cyc);
        phase(1'b1, 50);
        phase(1'b0, 30);
        rc2 = int'(cyc);
        phase(1'b1, 10);
        n_tests++;
        if (got_q.size() !== 2) begin
            n_fail++;
            $display("FAIL rmid_count: got %0d publishes, expected 2", got_q.size());
        end else begin
            n_tests++;
            if (got_q[0].off !== W'(3) || got_q[0].ovf !== 1'b0 || got_q[0].cyc !== rc1 + 3) begin
                n_fail++;
                $display("FAIL rmid_pub0: got off=%0d ovf=%b cyc=%0d, expected off=3 ovf=0 cyc=%0d",
                         got_q[0].off, got_q[0].ovf, got_q[0].cyc, rc1 + 3);
            end
            e = model(50, 30, rc2 + 3);
            n_tests++;
            if (got_q[1] !== e) begin
                n_fail++;
                $display("FAIL rmid_pub1: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         got_q[1].on, got_q[1].off, got_q[1].ovf, got_q[1].cyc, e.on, e.off, e.ovf, e.cyc);
            end
        end
    endtask

    task automatic test_pulse();
        do_reset();
        ph = '{1, 1, 1, 1};
        pl = '{25, 25, 25, 25};
        play();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL pulse_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL pulse_pub[%0d]: got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        ph.delete();
        pl.delete();
        for (int i = 0; i < 8; i++) begin
            ph.push_back((i == 3) ? int'($urandom_range(2550, 2700)) : int'($urandom_range(1, 250)));
            pl.push_back((i == 5) ? int'($urandom_range(2550, 2700)) : int'($urandom_range(1, 250)));
        end
        play();
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d publishes, expected %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_pub[%0d] (h=%0d l=%0d): got on=%0d off=%0d ovf=%b cyc=%0d, expected on=%0d off=%0d ovf=%b cyc=%0d",
                         i, ph[i], pl[i], got_q[i].on, got_q[i].off, got_q[i].ovf, got_q[i].cyc,
                         exp_q[i].on, exp_q[i].off, exp_q[i].ovf, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_generator();
        do_reset();
        sb_h.delete();
        sb_l.delete();
        @(negedge clk);
        #1;
        gen_wave = 1'b1;
        gen_cnt  = 0;
        sb_lvl   = 1'b1;
        sb_run   = 0;
        gen_en   = 1'b1;
        repeat (570) @(negedge clk);
        gen_en = 1'b0;
        n_tests++;
        if (got_q.size() !== sb_l.size() || got_q.size() == 0) begin
            n_fail++;
            $display("FAIL gen_count: got %0d publishes, expected %0d", got_q.size(), sb_l.size());
        end
        foreach (got_q[i]) if (i < sb_l.size()) begin
            n_tests++;
            if (got_q[i].on !== W'(sb_h[i] / P) || got_q[i].off !== W'(sb_l[i] / P) || got_q[i].ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL gen_pub[%0d]: got on=%0d off=%0d ovf=%b, expected on=%0d off=%0d ovf=0",
                         i, got_q[i].on, got_q[i].off, got_q[i].ovf, sb_h[i] / P, sb_l[i] / P);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_periodic();
        test_saturation();
        test_boundary();
        test_reset_mid();
        test_pulse();
        test_random();
        test_generator();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
